// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array job sequencer: state encoding,
// sa_inst bit positions and row-width helpers.
package sa_pkg;

    localparam int unsigned ELEM_W           = 16;
    localparam int unsigned ACC_W            = 32;
    localparam int unsigned DEF_ARRAY_LENGTH = 4;
    localparam int unsigned DEF_ARRAY_WIDTH  = 4;

    localparam int unsigned INST_WLOAD = 1;
    localparam int unsigned INST_W16   = 0;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StXfeed,
        StDrain,
        StFin
    } sa_state_e;

    function automatic int unsigned row_bits(input int unsigned elems, input int unsigned elem_w);
        return elems * elem_w;
    endfunction

endpackage

// File: rtl/sa_addr_counter.sv
// Base + count address generator with terminal-count and below-limit flags.
module sa_addr_counter
    import sa_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              _res,
    input  logic              clear,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  limit,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              below
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge _res) begin
        if (!_res) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Address wraps modulo 2^ADDR_W by truncation.
    assign addr  = base + ADDR_W'(count_q);
    assign last  = ((CNT_W+1)'(count_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(limit);
    assign below = count_q < limit;

endmodule

// File: rtl/systolic_sequencer.sv
// Job-level controller: loads one weight tile, streams input rows and writes
// every result row to the output buffer, with a bounded drain window.
module systolic_sequencer
    import sa_pkg::*;
#(
    parameter int unsigned ARRAY_LENGTH = DEF_ARRAY_LENGTH,
    parameter int unsigned ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DRAIN_MAX    = 64
) (
    input  logic                                    clk,
    input  logic                                    _res,
    input  logic                                    start,
    input  logic                                    width16,
    input  logic [15:0]                             num_rows,
    input  logic [ADDR_W-1:0]                       w_base,
    input  logic [ADDR_W-1:0]                       x_base,
    input  logic [ADDR_W-1:0]                       o_base,
    input  logic [row_bits(ARRAY_LENGTH, ACC_W)-1:0]  bias,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err,
    output logic                                    wrd_en,
    output logic [ADDR_W-1:0]                       wrd_addr,
    input  logic [row_bits(ARRAY_LENGTH, ELEM_W)-1:0] wrd_data,
    output logic                                    xrd_en,
    output logic [ADDR_W-1:0]                       xrd_addr,
    input  logic [row_bits(ARRAY_WIDTH, ELEM_W)-1:0]  xrd_data,
    output logic                                    owr_en,
    output logic [ADDR_W-1:0]                       owr_addr,
    output logic [row_bits(ARRAY_LENGTH, ACC_W)-1:0]  owr_data,
    output logic [1:0]                              sa_inst,
    output logic [row_bits(ARRAY_LENGTH, ELEM_W)-1:0] sa_WinL,
    output logic [row_bits(ARRAY_WIDTH, ELEM_W)-1:0]  sa_XinL,
    output logic [row_bits(ARRAY_LENGTH, ACC_W)-1:0]  sa_BinL,
    input  logic [row_bits(ARRAY_LENGTH, ACC_W)-1:0]  sa_SoutL,
    input  logic                                    sa_Sready
);

    localparam int unsigned S_ROW = row_bits(ARRAY_LENGTH, ACC_W);
    localparam int unsigned DRN_W = $clog2(DRAIN_MAX + 1);

    sa_state_e         state_q, state_d;
    logic              width16_q;
    logic [CNT_W-1:0]  num_rows_q;
    logic [ADDR_W-1:0] w_base_q, x_base_q, o_base_q;
    logic [S_ROW-1:0]  bias_q;
    logic              err_q, err_d;
    logic [DRN_W-1:0]  drain_q;
    logic              w_vld_q, x_vld_q;

    logic              accept, cap;
    logic [ADDR_W-1:0] w_addr, x_addr, o_addr;
    logic              w_last, x_last, o_last;
    logic              w_below, x_below, o_below;

    assign accept = (state_q == StIdle) && start;
    assign cap    = sa_Sready && o_below && ((state_q == StXfeed) || (state_q == StDrain));

    sa_addr_counter #(.ADDR_W(ADDR_W)) u_w_cnt (
        .clk   (clk),
        ._res  (_res),
        .clear (accept),
        .inc   (wrd_en),
        .base  (w_base_q),
        .limit (CNT_W'(ARRAY_WIDTH)),
        .addr  (w_addr),
        .last  (w_last),
        .below (w_below)
    );

    sa_addr_counter #(.ADDR_W(ADDR_W)) u_x_cnt (
        .clk   (clk),
        ._res  (_res),
        .clear (accept),
        .inc   (xrd_en),
        .base  (x_base_q),
        .limit (num_rows_q),
        .addr  (x_addr),
        .last  (x_last),
        .below (x_below)
    );

    sa_addr_counter #(.ADDR_W(ADDR_W)) u_o_cnt (
        .clk   (clk),
        ._res  (_res),
        .clear (accept),
        .inc   (cap),
        .base  (o_base_q),
        .limit (num_rows_q),
        .addr  (o_addr),
        .last  (o_last),
        .below (o_below)
    );

    always_ff @(posedge clk or negedge _res) begin
        if (!_res) begin
            state_q    <= StIdle;
            width16_q  <= 1'b0;
            num_rows_q <= '0;
            w_base_q   <= '0;
            x_base_q   <= '0;
            o_base_q   <= '0;
            bias_q     <= '0;
            err_q      <= 1'b0;
            drain_q    <= '0;
            w_vld_q    <= 1'b0;
            x_vld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            w_vld_q <= wrd_en;
            x_vld_q <= xrd_en;
            if (accept) begin
                width16_q  <= width16;
                num_rows_q <= num_rows;
                w_base_q   <= w_base;
                x_base_q   <= x_base;
                o_base_q   <= o_base;
                bias_q     <= bias;
                drain_q    <= '0;
            end else if (state_q == StDrain) begin
                drain_q <= drain_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWload;
                    err_d   = 1'b0;
                end
            end
            StWload: begin
                // An empty job spends one DRAIN cycle while the last weight lands.
                if (w_last) state_d = (num_rows_q == '0) ? StDrain : StXfeed;
            end
            StXfeed: begin
                if (x_last) state_d = StDrain;
            end
            StDrain: begin
                if (!o_below || (cap && o_last)) begin
                    state_d = StFin;
                end else if (drain_q == DRN_W'(DRAIN_MAX - 1)) begin
                    state_d = StFin;
                    err_d   = 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StWload) || (state_q == StXfeed) || (state_q == StDrain);
        done     = (state_q == StFin);
        err      = err_q;
        wrd_en   = (state_q == StWload) && w_below;
        wrd_addr = wrd_en ? w_addr : '0;
        xrd_en   = (state_q == StXfeed) && x_below;
        xrd_addr = xrd_en ? x_addr : '0;
        owr_en   = cap;
        owr_addr = cap ? o_addr : '0;
        owr_data = cap ? sa_SoutL : '0;
        sa_inst             = 2'b00;
        sa_inst[INST_WLOAD] = w_vld_q;
        sa_inst[INST_W16]   = width16_q;
        sa_WinL  = w_vld_q ? wrd_data : '0;
        sa_XinL  = x_vld_q ? xrd_data : '0;
        sa_BinL  = bias_q;
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench: table-driven and randomized jobs against a cycle-level
// reference derived from the job timing rules, plus reset/spurious corner cases.
module tb_systolic_sequencer;

    localparam int AL = 4;
    localparam int AW = 4;
    localparam int ADW = 10;
    localparam int DM = 64;
    localparam int AMOD = 1 << ADW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start = 1'b0, width16 = 1'b0;
    logic [15:0]    num_rows = '0;
    logic [ADW-1:0] w_base = '0, x_base = '0, o_base = '0;
    logic [127:0]   bias = '0;
    logic           busy, done, err;
    logic           wrd_en, xrd_en, owr_en;
    logic [ADW-1:0] wrd_addr, xrd_addr, owr_addr;
    logic [63:0]    wrd_data = '0, xrd_data = '0;
    logic [127:0]   owr_data;
    logic [1:0]     sa_inst;
    logic [63:0]    sa_WinL, sa_XinL;
    logic [127:0]   sa_BinL;
    logic [127:0]   sa_SoutL = '0;
    logic           sa_Sready = 1'b0;

    systolic_sequencer #(.ARRAY_LENGTH(AL), .ARRAY_WIDTH(AW), .ADDR_W(ADW), .DRAIN_MAX(DM)) dut (
        .clk(clk), ._res(rst_n), .start(start), .width16(width16), .num_rows(num_rows),
        .w_base(w_base), .x_base(x_base), .o_base(o_base), .bias(bias),
        .busy(busy), .done(done), .err(err),
        .wrd_en(wrd_en), .wrd_addr(wrd_addr), .wrd_data(wrd_data),
        .xrd_en(xrd_en), .xrd_addr(xrd_addr), .xrd_data(xrd_data),
        .owr_en(owr_en), .owr_addr(owr_addr), .owr_data(owr_data),
        .sa_inst(sa_inst), .sa_WinL(sa_WinL), .sa_XinL(sa_XinL), .sa_BinL(sa_BinL),
        .sa_SoutL(sa_SoutL), .sa_Sready(sa_Sready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] wmem [AMOD];
    logic [63:0] imem [AMOD];
    always @(posedge clk) begin
        if (wrd_en) wrd_data <= wmem[wrd_addr];
        if (xrd_en) xrd_data <= imem[xrd_addr];
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor logs, sampled mid-cycle.
    int          wa_q[$], wc_q[$], xa_q[$], xc_q[$], oa_q[$], dc_q[$];
    logic [63:0] win_q[$], xin_q[$];
    int          winst_q[$], xinst_q[$], derr_q[$], dbusy_q[$];
    logic [127:0] od_q[$];

    // Array model: each presented X row yields Sready 5 cycles later.
    int           pd_q[$];
    logic [127:0] pv_q[$];
    int           row_idx = 0;
    int           drop_idx = -1;
    bit           prev_x = 1'b0;
    bit           force_ready = 1'b0;

    always @(negedge clk) begin
        if (prev_x) begin
            xin_q.push_back(sa_XinL);
            xinst_q.push_back(int'(sa_inst));
            if (row_idx != drop_idx) begin
                pd_q.push_back(cyc + 5);
                pv_q.push_back({~sa_XinL, sa_XinL});
            end
            row_idx++;
        end
        prev_x = xrd_en;
        if (wrd_en) begin wa_q.push_back(int'(wrd_addr)); wc_q.push_back(cyc); end
        if (sa_inst[1]) begin win_q.push_back(sa_WinL); winst_q.push_back(int'(sa_inst)); end
        if (xrd_en) begin xa_q.push_back(int'(xrd_addr)); xc_q.push_back(cyc); end
        if (owr_en) begin oa_q.push_back(int'(owr_addr)); od_q.push_back(owr_data); end
        if (done) begin
            dc_q.push_back(cyc); derr_q.push_back(int'(err)); dbusy_q.push_back(int'(busy));
        end
    end

    always @(posedge clk) begin
        #2;
        while (pd_q.size() > 0 && pd_q[0] < cyc) begin
            void'(pd_q.pop_front()); void'(pv_q.pop_front());
        end
        sa_Sready = force_ready;
        sa_SoutL  = {$urandom, $urandom, $urandom, $urandom};
        if (pd_q.size() > 0 && pd_q[0] == cyc) begin
            sa_Sready = 1'b1;
            sa_SoutL  = pv_q.pop_front();
            void'(pd_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete(); wc_q.delete(); xa_q.delete(); xc_q.delete(); oa_q.delete();
        dc_q.delete(); win_q.delete(); xin_q.delete(); winst_q.delete(); xinst_q.delete();
        derr_q.delete(); dbusy_q.delete(); od_q.delete();
    endtask

    typedef struct {
        bit w16;
        int n;
        int wb, xb, ob;
        bit withhold;
        bit poke;
        int exp_writes;
        int exp_done;
        bit exp_err;
    } job_t;

    // Reference timing: weights at s+1..s+AW, rows from s+AW+1, results 6 cycles
    // after each read, done one cycle after the last write or DM+1 after the last read.
    function automatic job_t mk_job(bit w16, int n, int wb, int xb, int ob, bit wh, bit pk);
        job_t j;
        j.w16 = w16; j.n = n; j.wb = wb; j.xb = xb; j.ob = ob; j.withhold = wh; j.poke = pk;
        j.exp_writes = wh ? n - 1 : n;
        j.exp_err = wh;
        if (n == 0) j.exp_done = AW + 2;
        else if (wh) j.exp_done = AW + n + DM + 1;
        else j.exp_done = AW + n + 7;
        return j;
    endfunction

    task automatic run_job(input job_t v);
        int s, m, a;
        logic [127:0] b;
        clear_mon();
        row_idx = 0;
        drop_idx = v.withhold ? v.n - 1 : -1;
        b = {$urandom, $urandom, $urandom, $urandom};
        width16 = v.w16; num_rows = 16'(v.n); bias = b;
        w_base = ADW'(v.wb); x_base = ADW'(v.xb); o_base = ADW'(v.ob);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        @(negedge clk);
        chki("busy_after_start", int'(busy), 1);
        chki("err_clear_on_start", int'(err), 0);
        chkv("bias_fwd", sa_BinL, b);
        for (int i = 0; i < 400 && dc_q.size() == 0; i++) begin
            if (v.poke && cyc == s + 6) begin
                start = 1'b1; num_rows = num_rows + 16'd3; width16 = ~width16;
                x_base = x_base + ADW'(50); o_base = o_base + ADW'(9);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        repeat (3) tick();

        chki("wrd_count", wa_q.size(), AW);
        for (int k = 0; k < AW && k < wa_q.size(); k++)
            chki("wrd_addr", wa_q[k], (v.wb + k) % AMOD);
        if (wc_q.size() > 0) chki("wrd_first_cyc", wc_q[0] - s, 1);
        chki("winl_count", win_q.size(), AW);
        for (int k = 0; k < AW && k < win_q.size(); k++) begin
            a = (v.wb + k) % AMOD;
            chkv("sa_winl", 128'(win_q[k]), 128'(wmem[a]));
            chki("inst_wload", winst_q[k], v.w16 ? 3 : 2);
        end
        chki("xrd_count", xa_q.size(), v.n);
        for (int r = 0; r < v.n && r < xa_q.size(); r++)
            chki("xrd_addr", xa_q[r], (v.xb + r) % AMOD);
        if (v.n > 0 && xc_q.size() > 0) chki("xrd_first_cyc", xc_q[0] - s, AW + 1);
        for (int r = 0; r < v.n && r < xin_q.size(); r++) begin
            a = (v.xb + r) % AMOD;
            chkv("sa_xinl", 128'(xin_q[r]), 128'(imem[a]));
            chki("inst_pass", xinst_q[r], v.w16 ? 1 : 0);
        end
        m = v.exp_writes;
        chki("owr_count", oa_q.size(), m);
        for (int i = 0; i < m && i < oa_q.size(); i++) begin
            a = (v.xb + i) % AMOD;
            chki("owr_addr", oa_q[i], (v.ob + i) % AMOD);
            chkv("owr_data", od_q[i], {~imem[a], imem[a]});
        end
        chki("done_count", dc_q.size(), 1);
        if (dc_q.size() > 0) begin
            chki("done_cyc", dc_q[0] - s, v.exp_done);
            chki("err_at_done", derr_q[0], int'(v.exp_err));
            chki("busy_at_done", dbusy_q[0], 0);
        end
        chki("err_held", int'(err), int'(v.exp_err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chki({tag, "_ctl"}, int'({busy, done, err, wrd_en, xrd_en, owr_en}), 0);
        chki({tag, "_addr"}, int'({wrd_addr, xrd_addr, owr_addr}), 0);
        chki({tag, "_inst"}, int'(sa_inst), 0);
        chkv({tag, "_winl_xinl"}, {sa_WinL, sa_XinL}, '0);
        chkv({tag, "_binl"}, sa_BinL, '0);
        chkv({tag, "_owr_data"}, owr_data, '0);
    endtask

    job_t vec[6];

    initial begin
        int s;
        job_t r;
        for (int i = 0; i < AMOD; i++) begin
            wmem[i] = {$urandom, $urandom};
            imem[i] = {$urandom, $urandom};
        end
        vec[0] = mk_job(1'b0, 3, 10, 20, 30, 1'b0, 1'b0);
        vec[1] = mk_job(1'b1, 0, 1020, 5, 7, 1'b0, 1'b0);
        vec[2] = mk_job(1'b0, 4, 3, 1022, 500, 1'b0, 1'b0);
        vec[3] = mk_job(1'b1, 2, 40, 50, 60, 1'b1, 1'b0);
        vec[4] = mk_job(1'b1, 5, 100, 200, 1021, 1'b0, 1'b0);
        vec[5] = mk_job(1'b0, 4, 7, 300, 400, 1'b0, 1'b1);

        rst_n = 1'b0;
        #1;
        chk_reset_vals("por");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Sready while idle must not write.
        clear_mon();
        force_ready = 1'b1;
        repeat (5) tick();
        force_ready = 1'b0;
        tick();
        chki("idle_sready_writes", oa_q.size(), 0);
        chki("idle_sready_done", dc_q.size(), 0);

        for (int i = 0; i < 6; i++) begin
            run_job(vec[i]);
            repeat (2) tick();
        end

        for (int i = 0; i < 6; i++) begin
            bit w16, wh, pk;
            int n;
            w16 = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 8);
            wh = (n > 0) && ($urandom_range(0, 3) == 0);
            pk = (n >= 3) && ($urandom_range(0, 1) == 1);
            r = mk_job(w16, n, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
                       $urandom_range(0, AMOD - 1), wh, pk);
            run_job(r);
            tick();
        end

        // Reset during DRAIN aborts the job.
        clear_mon();
        row_idx = 0; drop_idx = -1;
        width16 = 1'b1; num_rows = 16'd4; bias = {4{32'hdeadbeef}};
        w_base = ADW'(11); x_base = ADW'(12); o_base = ADW'(13);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        while (cyc < s + 10) tick();
        force_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midjob");
        tick();
        rst_n = 1'b1;
        force_ready = 1'b0;
        clear_mon();
        repeat (30) tick();
        chki("rst_no_done", dc_q.size(), 0);
        chki("rst_no_writes", oa_q.size(), 0);
        chki("rst_no_reads", wa_q.size() + xa_q.size(), 0);

        run_job(vec[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
